// File: rtl/shift_register_universal_if.sv
// Control/data bundle for shift_register_universal: requests, operands and results.
// The master side drives requests; the slave side (the register) returns state.
interface shift_register_universal_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
);
  logic [WIDTH-1:0]   d;
  logic               load;
  logic               shift;
  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic               shift_in;
  logic [WIDTH-1:0]   q;
  logic               shift_out;
  logic               busy;
  logic               done;

  modport master (
    output d, load, shift, start, mode, shamt, shift_in,
    input  q, shift_out, busy, done
  );

  modport slave (
    input  d, load, shift, start, mode, shamt, shift_in,
    output q, shift_out, busy, done
  );
endinterface

// File: rtl/shift_register_universal.sv
// Universal shift register: parallel load, single-step shift and a sequenced
// shift-by-N with start/busy/done, in four modes (lsl, lsr, rol, asr).
module shift_register_universal #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  shift_register_universal_if.slave     bus
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  if ((WIDTH < 2) || ((2 ** SHAMT_W) < WIDTH)) begin : g_param_check
    $error("shift_register_universal: WIDTH must be >= 2 and SHAMT_W >= clog2(WIDTH)");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               so_q, so_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         mode_q, mode_d;
  logic [SHAMT_W-1:0] remaining_q, remaining_d;

  // Result of one step: {bit shifted out, new register value}.
  function automatic logic [WIDTH:0] step(input logic [WIDTH-1:0] q,
                                          input logic [1:0]       m,
                                          input logic             sin);
    logic [WIDTH:0] res;
    res = {1'b0, q};
    unique case (m)
      2'b00:   res = {q[WIDTH-1], q[WIDTH-2:0], sin};
      2'b01:   res = {q[0], sin, q[WIDTH-1:1]};
      2'b10:   res = {q[WIDTH-1], q[WIDTH-2:0], q[WIDTH-1]};
      default: res = {q[0], q[WIDTH-1], q[WIDTH-1:1]};
    endcase
    return res;
  endfunction

  logic [WIDTH:0] live_step;
  logic [WIDTH:0] seq_step;

  assign live_step = step(q_q, bus.mode, bus.shift_in);
  assign seq_step  = step(q_q, mode_q, bus.shift_in);

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    so_d        = so_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mode_d      = mode_q;
    remaining_d = remaining_q;

    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          q_d = bus.d;
        end else if (bus.start) begin
          mode_d = bus.mode;
          if (bus.shamt == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = bus.shamt;
            state_d     = StShift;
            busy_d      = 1'b1;
          end
        end else if (bus.shift) begin
          q_d  = live_step[WIDTH-1:0];
          so_d = live_step[WIDTH];
        end
      end
      StShift: begin
        // Request inputs are deliberately ignored here; only shift_in is live.
        q_d         = seq_step[WIDTH-1:0];
        so_d        = seq_step[WIDTH];
        remaining_d = remaining_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (remaining_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      q_q         <= '0;
      so_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= 2'b00;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      so_q        <= so_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.shift_out = so_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_shift_register_universal.sv
// Directed bench for shift_register_universal (WIDTH=8) with an arithmetic
// reference model checked every cycle plus hand-computed literal checkpoints.
module tb_shift_register_universal;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  shift_register_universal_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  shift_register_universal #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each step expressed as integer arithmetic on an 8-bit value.
  function automatic int ref_next(int q, int m, int sin);
    case (m)
      0:       return (q * 2 + sin) % 256;
      1:       return q / 2 + sin * 128;
      2:       return (q * 2) % 256 + q / 128;
      default: return q / 2 + (q / 128) * 128;
    endcase
  endfunction

  function automatic int ref_out(int q, int m);
    if (m == 0 || m == 2) return q / 128;
    return q % 2;
  endfunction

  int m_q;
  int m_so;
  int m_busy;
  int m_done;
  int m_left;
  int m_mode;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 0; m_so <= 0; m_busy <= 0; m_done <= 0; m_left <= 0; m_mode <= 0;
    end else begin
      m_done <= 0;
      if (m_left > 0) begin
        m_q    <= ref_next(m_q, m_mode, int'(bus.shift_in));
        m_so   <= ref_out(m_q, m_mode);
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 0;
          m_done <= 1;
        end
      end else if (bus.load) begin
        m_q <= int'(bus.d);
      end else if (bus.start) begin
        m_mode <= int'(bus.mode);
        if (bus.shamt == 3'd0) begin
          m_done <= 1;
        end else begin
          m_left <= int'(bus.shamt);
          m_busy <= 1;
        end
      end else if (bus.shift) begin
        m_q  <= ref_next(m_q, int'(bus.mode), int'(bus.shift_in));
        m_so <= ref_out(m_q, int'(bus.mode));
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_q", int'(bus.q), m_q);
      check("model_shift_out", int'(bus.shift_out), m_so);
      check("model_busy", int'(bus.busy), m_busy);
      check("model_done", int'(bus.done), m_done);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    bus.d = '0; bus.load = 0; bus.shift = 0; bus.start = 0;
    bus.mode = 2'b00; bus.shamt = '0; bus.shift_in = 0;
    #1 rst_n = 1'b0;
    #2;
    check("reset_q", int'(bus.q), 0);
    check("reset_so", int'(bus.shift_out), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Load then single logical-left step.
    bus.load = 1; bus.d = 8'hA5;
    cycle();
    check("load_a5", int'(bus.q), 8'hA5);
    bus.load = 0; bus.shift = 1; bus.mode = 2'b00; bus.shift_in = 1;
    cycle();
    check("lsl_q", int'(bus.q), 8'h4B);
    check("lsl_so", int'(bus.shift_out), 1);
    bus.shift = 0;

    // Rotate left by 3.
    bus.load = 1; bus.d = 8'h81;
    cycle();
    bus.load = 0; bus.start = 1; bus.mode = 2'b10; bus.shamt = 3'd3;
    cycle();
    check("rol_busy0", int'(bus.busy), 1);
    check("rol_q0", int'(bus.q), 8'h81);
    bus.start = 0;
    cycle();
    check("rol_q1", int'(bus.q), 8'h03);
    check("rol_busy1", int'(bus.busy), 1);
    cycle();
    check("rol_q2", int'(bus.q), 8'h06);
    cycle();
    check("rol_q3", int'(bus.q), 8'h0C);
    check("rol_done", int'(bus.done), 1);
    check("rol_busy3", int'(bus.busy), 0);
    check("rol_so", int'(bus.shift_out), 0);
    cycle();
    check("rol_done_drop", int'(bus.done), 0);

    // Arithmetic right by 2; mode changes during busy must not matter.
    bus.load = 1; bus.d = 8'h90;
    cycle();
    bus.load = 0; bus.start = 1; bus.mode = 2'b11; bus.shamt = 3'd2;
    cycle();
    bus.start = 0; bus.mode = 2'b00;
    cycle();
    check("asr_q1", int'(bus.q), 8'hC8);
    cycle();
    check("asr_q2", int'(bus.q), 8'hE4);
    check("asr_so", int'(bus.shift_out), 0);
    check("asr_done", int'(bus.done), 1);

    // shamt=0 start issued in the done cycle.
    bus.start = 1; bus.shamt = 3'd0;
    cycle();
    check("zero_done", int'(bus.done), 1);
    check("zero_busy", int'(bus.busy), 0);
    check("zero_q", int'(bus.q), 8'hE4);
    bus.start = 0;
    cycle();
    check("zero_done_drop", int'(bus.done), 0);

    // Load during busy is ignored.
    bus.start = 1; bus.mode = 2'b01; bus.shift_in = 0; bus.shamt = 3'd2;
    cycle();
    check("ign_busy", int'(bus.busy), 1);
    bus.start = 0; bus.load = 1; bus.d = 8'h55;
    cycle();
    check("ign_q1", int'(bus.q), 8'h72);
    cycle();
    check("ign_q2", int'(bus.q), 8'h39);
    check("ign_done", int'(bus.done), 1);

    // Back-to-back start accepted in the done cycle.
    bus.load = 0; bus.start = 1; bus.mode = 2'b00; bus.shamt = 3'd1; bus.shift_in = 1;
    cycle();
    check("b2b_busy", int'(bus.busy), 1);
    check("b2b_q0", int'(bus.q), 8'h39);
    bus.start = 0;
    cycle();
    check("b2b_q1", int'(bus.q), 8'h73);
    check("b2b_done", int'(bus.done), 1);

    // Asynchronous reset in the middle of a 5-step sequence.
    bus.load = 1; bus.d = 8'hF0;
    cycle();
    bus.load = 0; bus.start = 1; bus.mode = 2'b01; bus.shift_in = 0; bus.shamt = 3'd5;
    cycle();
    bus.start = 0;
    cycle();
    check("mid_q1", int'(bus.q), 8'h78);
    cycle();
    check("mid_q2", int'(bus.q), 8'h3C);
    check("mid_busy", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", int'(bus.q), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_so", int'(bus.shift_out), 0);
    cycle();
    check("arst_hold_done", int'(bus.done), 0);
    check("arst_hold_q", int'(bus.q), 0);
    rst_n = 1'b1;
    bus.start = 1; bus.mode = 2'b01; bus.shamt = 3'd1; bus.shift_in = 1;
    cycle();
    check("post_busy", int'(bus.busy), 1);
    bus.start = 0;
    cycle();
    check("post_q", int'(bus.q), 8'h80);
    check("post_done", int'(bus.done), 1);
    cycle();
    check("post_done_drop", int'(bus.done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_register_universal.md
# shift_register_universal

Parametrised universal shift register, the next generation of the fixed 8-bit shift register. It adds a configurable width, four shift modes and a multi-cycle shift-by-N sequencer with a start/busy/done handshake. Parallel load and single-step shift are retained. It serves as the general-purpose shifting element of the ULA datapath (multi-bit shifts, rotates, arithmetic right shift) under control-unit sequencing.

## Interface
- WIDTH, default 8: register width in bits; must be 2 or more.
- SHAMT_W, default 3: width of the shift-amount input; must be at least ceil(log2(WIDTH)).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset; clears all state immediately.
- D  in  WIDTH  parallel load data.
- load  in  1  parallel load request, active high.
- shift  in  1  single-step shift request, active high; uses the current mode.
- start  in  1  multi-cycle shift request, active high.
- mode  in  2  shift mode:
  - 00 = logical left: shift_in enters bit 0.
  - 01 = logical right: shift_in enters bit WIDTH-1.
  - 10 = rotate left: old MSB enters bit 0.
  - 11 = arithmetic right: old MSB is replicated.
- shamt  in  SHAMT_W  number of single-bit steps for a start request.
- shift_in  in  1  serial input bit; sampled on every step.
- Q  out  WIDTH  parallel register contents.
- shift_out  out  1  registered copy of the bit that left the register on the most recent step.
- busy  out  1  high while a multi-cycle shift is in progress.
- done  out  1  one-cycle pulse when a start request completes.

## Operation
- Two FSM states, IDLE and SHIFT. Reset values: state IDLE, Q=0, shift_out=0, busy=0, done=0.
- In IDLE, requests have priority load > start > shift, and only one action is taken per edge:
  - load: Q<=D. shift_out is unchanged.
  - start: latch mode and shamt into internal registers.
    - If shamt=0: stay in IDLE, Q unchanged, done=1 next cycle.
    - Otherwise: remaining<=shamt, go to SHIFT, busy<=1.
  - shift: perform one step using the live mode and shift_in; stay in IDLE.
  - No request: hold.
- In SHIFT:
  - Each edge performs one step with the latched mode and the live shift_in, and decrements remaining.
  - The step that takes remaining from 1 to 0 also sets state<=IDLE, busy<=0, done<=1.
- Inputs load, shift, start, mode and shamt are ignored while in SHIFT. They are neither queued nor allowed to alter the latched mode.
- Step definitions, with the old value written q:
  - 00: Q<={q[W-2:0],shift_in}, shift_out<=q[W-1].
  - 01: Q<={shift_in,q[W-1:1]}, shift_out<=q[0].
  - 10: Q<={q[W-2:0],q[W-1]}, shift_out<=q[W-1].
  - 11: Q<={q[W-1],q[W-1:1]}, shift_out<=q[0].
- shamt may be WIDTH or larger (when SHAMT_W allows). All shamt steps are performed literally; there is no saturation or modulo.
- done is 0 in every cycle except the single pulse cycle. A new start accepted in the pulse cycle is legal.
- Reset asserted mid-operation: return to IDLE immediately with all reset values. The operation in progress is abandoned and no done pulse is produced.

## Timing
- Load and single-step shift: result visible in Q one edge after the request is sampled.
- start with shamt=N>0 sampled at edge k:
  - busy is high after edge k through edge k+N-1.
  - After edge k+j (1<=j<=N), Q holds j steps.
  - After edge k+N: busy=0, done=1 for exactly one cycle, Q is final.
- start with shamt=0 sampled at edge k: done is high for the cycle after edge k; busy stays 0.
- Back-to-back: a start sampled in the done cycle begins the new sequence at that edge.
- Reset is asynchronous. Release is synchronous to the next edge; the first action occurs at the first edge after rst goes high.

## Test plan
- Reset: drive rst=0 mid-cycle while Q=0xFF and busy=1 -> Q=0x00, busy=0, done=0, shift_out=0 immediately, without waiting for a clock edge.
- Load and single step (WIDTH=8): load D=0xA5, then shift with mode=00 and shift_in=1 -> Q=0x4B, shift_out=1 one cycle later.
- Rotate: load 0x81, then start with mode=10 and shamt=3 -> Q steps 0x03, 0x06, 0x0C; busy high for 3 cycles; done pulses for 1 cycle; shift_out=0.
- Arithmetic right: load 0x90, then start with mode=11 and shamt=2 -> Q=0xC8, then 0xE4; shift_out=0. Changing mode to 00 during busy has no effect.
- Degenerate and ignored inputs:
  - start with shamt=0 -> done one cycle later, busy never asserts, Q unchanged.
  - load 0x55 asserted during busy -> ignored.
- Reset mid-shift: load 0xF0, start with mode=01, shift_in=0, shamt=5; drop rst after 2 steps -> all outputs cleared and no done pulse. After release, start with mode=01, shamt=1, shift_in=1 -> Q=0x80 and done pulses.
